// File: rtl/sort_serializer.sv
// sort_serializer: serialises one sorted packed vector per handshake into a
// stream of n elements, each tagged with its index and a last flag.
// Optional build macro SORT_SERIALIZER_ORDER_CHECK_EN adds a sticky err_order
// flag that is raised when a captured vector is not ascending (unsigned).
module sort_serializer #(
    parameter int unsigned n = 8,
    parameter int unsigned k = 4,
    localparam int unsigned IW = $clog2(n)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [n*k-1:0]  in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [k-1:0]    out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            err_order
);

    localparam logic [IW-1:0] LastIdx = IW'(n - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e           r_state;
    logic [n*k-1:0]   r_hold;
    logic [IW-1:0]    r_idx;
    logic             r_out_valid;
    logic [k-1:0]     r_out_data;
    logic             r_out_last;

    logic             w_is_last;
    logic             w_load;
    logic [IW-1:0]    w_next_idx;
    logic [k-1:0]     w_hold_el [n];

    // Element view of the holding register.
    for (genvar g = 0; g < int'(n); g++) begin : g_hold_el
        assign w_hold_el[g] = r_hold[g*k +: k];
    end

    assign w_is_last  = (r_idx == LastIdx);
    assign w_next_idx = r_idx + IW'(1);

    // Accept in IDLE, or on the last beat of the current vector.
    always_comb begin
        in_ready = 1'b1;
        if (r_state == StSend) begin
            in_ready = w_is_last & out_ready;
        end
    end

    assign w_load = in_valid & in_ready;

    // Serializer FSM: capture, step through elements, registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            // New vector; in SEND this only happens on the last beat.
            r_state     <= StSend;
            r_hold      <= in;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= in[k-1:0];
            r_out_last  <= 1'b0;
        end else if (r_state == StSend && out_ready) begin
            if (!w_is_last) begin
                r_idx      <= w_next_idx;
                r_out_data <= w_hold_el[w_next_idx];
                r_out_last <= (w_next_idx == LastIdx);
            end else begin
                // Last beat taken with nothing waiting: idx stays n-1 until next capture.
                r_state     <= StIdle;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_idx;
    assign out_last  = r_out_last;

`ifdef SORT_SERIALIZER_ORDER_CHECK_EN
    logic w_order_bad;
    logic r_err_order;

    // Flag any adjacent pair of the incoming vector that descends.
    always_comb begin
        w_order_bad = 1'b0;
        for (int i = 0; i < int'(n) - 1; i++) begin
            if (in[i*k +: k] > in[(i+1)*k +: k]) begin
                w_order_bad = 1'b1;
            end
        end
    end

    // Sticky error, set on the capture edge of an unsorted vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_order <= 1'b0;
        end else if (w_load && w_order_bad) begin
            r_err_order <= 1'b1;
        end
    end

    assign err_order = r_err_order;
`else
    assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_sort_serializer.sv
// Directed testbench for sort_serializer (n=8, k=4).
module tb_sort_serializer;

    localparam bit OrderCheck =
`ifdef SORT_SERIALIZER_ORDER_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        err_order;

    int n_vec;
    int n_err;

    sort_serializer #(
        .n(8),
        .k(4)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err_order (err_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One output beat: valid element with given data/index.
    task automatic beat(input string tag, input logic [3:0] d, input int i, input logic rdy);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_idx"},   32'(out_idx),   32'(i));
        chk({tag, "_last"},  32'(out_last),  32'(i == 7));
        chk({tag, "_inrdy"}, 32'(in_ready),  32'(rdy));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_inrdy"}, 32'(in_ready),  32'd1);
        chk({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    // Hand-written element sequences.
    logic [3:0] seq1 [8] = '{4'h1, 4'h2, 4'h2, 4'h5, 4'h7, 4'h9, 4'hC, 4'hF};
    logic [3:0] seq6 [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inrdy", 32'(in_ready),  32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_idx",   32'(out_idx),   32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_err",   32'(err_order), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single vector 1,2,2,5,7,9,C,F
        @(negedge clk);
        in_vec   = 32'hFC975221;
        in_valid = 1'b1;
        #1;
        chk("t1_accept", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            beat("t1", seq1[i], i, i == 7);
        end
        @(negedge clk);
        #1;
        idle_chk("t1_idle");

        // Back-to-back: all 3s then 0..7
        @(negedge clk);
        in_vec   = 32'h33333333;
        in_valid = 1'b1;
        #1;
        chk("t2_accept", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) in_vec = 32'h76543210;
            #1;
            beat("t2a", 4'h3, i, i == 7);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            #1;
            beat("t2b", 4'(i), i, i == 7);
        end
        @(negedge clk);
        #1;
        idle_chk("t2_idle");

        // Back-pressure at idx 4 for three cycles
        @(negedge clk);
        in_vec   = 32'hFC975221;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            beat("t3", seq1[i], i, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 32'h00000000;
        #1;
        beat("t3_stall", 4'h7, 4, 1'b0);
        repeat (2) begin
            @(negedge clk);
            #1;
            beat("t3_stall", 4'h7, 4, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        beat("t3_stall", 4'h7, 4, 1'b0);
        for (int i = 5; i < 8; i++) begin
            @(negedge clk);
            #1;
            beat("t3_resume", seq1[i], i, i == 7);
        end
        @(negedge clk);
        #1;
        idle_chk("t3_idle");

        // Asynchronous reset at idx 3
        @(negedge clk);
        in_vec   = 32'h76543210;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            beat("t4", 4'(i), i, 1'b0);
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("t4_async_valid", 32'(out_valid), 32'd0);
        chk("t4_async_inrdy", 32'(in_ready),  32'd1);
        chk("t4_async_idx",   32'(out_idx),   32'd0);
        chk("t4_async_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            idle_chk("t4_post");
        end

        // Input changes every cycle while busy
        @(negedge clk);
        in_vec   = 32'h76543210;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_vec = (i == 7) ? 32'hFEDCBA98 : 32'h11111111 * (i + 1);
            #1;
            beat("t5a", 4'(i), i, i == 7);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            #1;
            beat("t5b", 4'(8 + i), i, i == 7);
        end
        @(negedge clk);
        #1;
        idle_chk("t5_idle");
        chk("t6_err_sorted", 32'(err_order), 32'd0);

        // Order check: unsorted vector 0,1,2,3,4,5,7,6
        @(negedge clk);
        in_vec   = 32'h67543210;
        in_valid = 1'b1;
        #1;
        chk("t6_err_pre", 32'(err_order), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (i == 0) chk("t6_err_set", 32'(err_order), 32'(OrderCheck));
            beat("t6", seq6[i], i, i == 7);
        end
        @(negedge clk);
        in_vec   = 32'h76543210;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            beat("t6b", 4'(i), i, i == 7);
        end
        @(negedge clk);
        #1;
        idle_chk("t6_idle");
        chk("t6_err_sticky", 32'(err_order), 32'(OrderCheck));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
